// File: rtl/top_datapath.sv
// ---------------------------------------------------------------------------
// top_datapath
//   Flat-bus arithmetic datapath. A 137-bit input bus is sliced into four
//   32-bit operands plus control. Every result is held in a flop, so each
//   output field shows the inputs sampled at the previous rising clock edge.
//
// Ports
//   clk       in   1    single clock, rising edge
//   rst_n     in   1    asynchronous reset, ACTIVE-HIGH despite the name
//   in_flat   in   137  [31:0]=A [63:32]=B [95:64]=C [127:96]=D
//                       [130:128]=OP [131]=VALID [132]=ACC_CLR [133]=ACC_EN
//                       [136:134]=ROT_SEL
//   out_flat  out  159  [31:0]=ALU_Q [63:32]=ROT_Q [127:64]=ACC [143:128]=SIG
//                       [151:144]=CNT [157:152]=POP [158]=VALID_Q
//
// Configuration
//   SAT_ACC_EN  when defined, the accumulator saturates at all-ones instead
//               of wrapping modulo 2^64.
// ---------------------------------------------------------------------------
module top_datapath (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [136:0]   in_flat,
  output logic [158:0]   out_flat
);

  // Input bus slices
  logic [31:0] a, b, c, d;
  logic [2:0]  op, rot_sel;
  logic        valid, acc_clr, acc_en;

  assign a       = in_flat[31:0];
  assign b       = in_flat[63:32];
  assign c       = in_flat[95:64];
  assign d       = in_flat[127:96];
  assign op      = in_flat[130:128];
  assign valid   = in_flat[131];
  assign acc_clr = in_flat[132];
  assign acc_en  = in_flat[133];
  assign rot_sel = in_flat[136:134];

  // Only the low half of C feeds the signature register.
  logic unused_c_hi;
  assign unused_c_hi = ^c[31:16];

  // State
  logic [31:0] alu_q,   alu_d;
  logic [31:0] rot_q,   rot_d;
  logic [63:0] acc_q,   acc_d;
  logic [15:0] sig_q,   sig_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [5:0]  pop_q,   pop_d;
  logic        valid_q, valid_d;

  // Intermediates
  logic [31:0] alu_res;
  logic [63:0] rot_wide;
  logic [63:0] prod;
`ifdef SAT_ACC_EN
  logic [64:0] acc_sum;   // extra bit carries the overflow flag
`else
  logic [63:0] acc_sum;
`endif

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

  // ALU operation select
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    case (op)
      3'd0: alu_res = a + b;
      3'd1: alu_res = a - b;
      3'd2: alu_res = a & b;
      3'd3: alu_res = a | b;
      3'd4: alu_res = a ^ b;
      3'd5: alu_res = a << b[4:0];
      3'd6: alu_res = a >> b[4:0];
      3'd7: alu_res = {31'b0, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Rotate-left by 4*ROT_SEL: shift a doubled copy and keep the upper word.
  assign rot_wide = {d, d} << {rot_sel, 2'b00};

  assign prod = {32'b0, a} * {32'b0, b};

`ifdef SAT_ACC_EN
  assign acc_sum = {1'b0, acc_q} + {1'b0, prod};
`else
  assign acc_sum = acc_q + prod;
`endif

  // Next-state logic
  always_comb begin
    alu_d   = alu_q;
    pop_d   = pop_q;
    rot_d   = rot_q;
    sig_d   = sig_q;
    acc_d   = acc_q;
    valid_d = valid;
    cnt_d   = cnt_q + 8'd1;

    if (valid) begin
      alu_d = alu_res;
      pop_d = popcount32(alu_res);
      rot_d = rot_wide[63:32];
      sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ c[15:0];
    end

    // Clear wins over accumulate regardless of VALID/ACC_EN.
    if (acc_clr) begin
      acc_d = '0;
    end else if (valid && acc_en) begin
`ifdef SAT_ACC_EN
      acc_d = acc_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : acc_sum[63:0];
`else
      acc_d = acc_sum;
`endif
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      alu_q   <= '0;
      pop_q   <= '0;
      rot_q   <= '0;
      sig_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      alu_q   <= alu_d;
      pop_q   <= pop_d;
      rot_q   <= rot_d;
      sig_q   <= sig_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_flat = {valid_q, pop_q, cnt_q, sig_q, acc_q, rot_q, alu_q};

endmodule

// File: tb/tb_top_datapath.sv
// ---------------------------------------------------------------------------
// tb_top_datapath
//   Directed, self-checking bench for top_datapath. Inputs change 1 time unit
//   after a rising edge; outputs are checked at that same point, well away
//   from the next edge.
// ---------------------------------------------------------------------------
module tb_top_datapath;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [136:0] in_flat;
  logic [158:0] out_flat;

  logic [31:0] a, b, c, d;
  logic [2:0]  op, rot_sel;
  logic        valid, acc_clr, acc_en;

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_cnt = '0;

  assign in_flat = {rot_sel, acc_en, acc_clr, valid, op, d, c, b, a};

  always #5 clk = ~clk;

  top_datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  task automatic check(input string tag, input logic [158:0] obs, input logic [158:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with reset released; the bench's own count model advances.
  task automatic step();
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  logic [63:0] exp_acc_ovf;

  initial begin
    a = '0; b = '0; c = '0; d = '0; op = '0; rot_sel = '0;
    valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_all_zero", out_flat, '0);

    // Release and count from the first edge.
    rst_n = 1'b0;
    exp_cnt = '0;
    step();
    check("cnt_after_release", out_flat[151:144], 8'd1);
    check("valid_q_low", out_flat[158], 1'b0);

    // ALU add wrap
    a = 32'hFFFF_FFFF; b = 32'd1; op = 3'd0; valid = 1'b1;
    step();
    check("add_wrap_alu", out_flat[31:0], 32'h0);
    check("add_wrap_pop", out_flat[157:152], 6'd0);
    check("valid_q_high", out_flat[158], 1'b1);
    check("cnt_2", out_flat[151:144], 8'd2);

    // Signed less-than
    a = 32'h8000_0000; b = 32'd0; op = 3'd7;
    step();
    check("slt_alu", out_flat[31:0], 32'd1);
    check("slt_pop", out_flat[157:152], 6'd1);

    // Subtract borrow
    a = 32'd5; b = 32'd7; op = 3'd1;
    step();
    check("sub_alu", out_flat[31:0], 32'hFFFF_FFFE);
    check("sub_pop", out_flat[157:152], 6'd31);

    // AND
    a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; op = 3'd2;
    step();
    check("and_alu", out_flat[31:0], 32'hF000_F000);
    check("and_pop", out_flat[157:152], 6'd8);

    // Shift left uses only B[4:0]
    a = 32'd1; b = 32'h0000_003F; op = 3'd5;
    step();
    check("shl_alu", out_flat[31:0], 32'h8000_0000);

    // Logical shift right
    a = 32'h8000_0000; b = 32'd31; op = 3'd6;
    step();
    check("shr_alu", out_flat[31:0], 32'd1);

    // XOR and OR; full popcount
    a = 32'hFFFF_0000; b = 32'h0000_FFFF; op = 3'd4;
    step();
    check("xor_alu", out_flat[31:0], 32'hFFFF_FFFF);
    check("xor_pop", out_flat[157:152], 6'd32);
    a = 32'h0000_0011; b = 32'h0000_0100; op = 3'd3;
    step();
    check("or_alu", out_flat[31:0], 32'h0000_0111);

    // Rotate
    d = 32'h1234_5678; rot_sel = 3'd1;
    step();
    check("rot_4", out_flat[63:32], 32'h2345_6781);
    rot_sel = 3'd0;
    step();
    check("rot_0", out_flat[63:32], 32'h1234_5678);
    rot_sel = 3'd7;
    step();
    check("rot_28", out_flat[63:32], 32'h8123_4567);

    // MISR: signature is still 0 since C has been 0 throughout
    check("sig_zero", out_flat[143:128], 16'h0);
    c = 32'h0000_0001;
    step();
    check("sig_1", out_flat[143:128], 16'h0001);
    c = 32'h0;
    step();
    check("sig_2", out_flat[143:128], 16'h0002);
    c = 32'h0000_8000;
    step();
    check("sig_3", out_flat[143:128], 16'h8004);
    c = 32'h0;
    step();
    check("sig_fb", out_flat[143:128], 16'h0009);

    // Hold with VALID=0: state at this point is ALU=0x111, POP=3, ROT=0x81234567, SIG=0x0009
    valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_0000; c = 32'hFFFF_FFFF; d = 32'hCAFE_F00D; op = 3'd0;
    rot_sel = 3'd2;
    step();
    check("hold_alu", out_flat[31:0], 32'h0000_0111);
    check("hold_pop", out_flat[157:152], 6'd3);
    check("hold_rot", out_flat[63:32], 32'h8123_4567);
    check("hold_sig", out_flat[143:128], 16'h0009);
    check("hold_valid_q", out_flat[158], 1'b0);
    check("hold_acc", out_flat[127:64], 64'h0);

    // MAC
    acc_clr = 1'b1;
    step();
    check("mac_clr", out_flat[127:64], 64'h0);
    acc_clr = 1'b0; acc_en = 1'b1; valid = 1'b1; a = 32'd2; b = 32'd3;
    step();
    check("mac_6", out_flat[127:64], 64'd6);
    step();
    check("mac_12", out_flat[127:64], 64'd12);
    step();
    check("mac_18", out_flat[127:64], 64'd18);
    valid = 1'b0;
    step();
    check("mac_hold_no_valid", out_flat[127:64], 64'd18);
    valid = 1'b1; acc_clr = 1'b1;
    step();
    check("mac_clr_priority", out_flat[127:64], 64'h0);

    // Drive ACC to all-ones, then add 2*3
    acc_clr = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    check("mac_big", out_flat[127:64], 64'hFFFF_FFFE_0000_0001);
    b = 32'd2;
    step();
    check("mac_max", out_flat[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    a = 32'd2; b = 32'd3;
`ifdef SAT_ACC_EN
    exp_acc_ovf = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_acc_ovf = 64'd5;
`endif
    step();
    check("mac_overflow", out_flat[127:64], exp_acc_ovf);
    acc_en = 1'b0; valid = 1'b0;

    // Counter wrap: advance until the model reaches 0 (bounded by 256 clocks)
    for (int i = 0; i < 256 && exp_cnt != 8'd0; i++) step();
    check("cnt_wrap_0", out_flat[151:144], 8'd0);
    check("cnt_model_0", {151'b0, exp_cnt}, '0);
    repeat (256) step();
    check("cnt_wrap_256", out_flat[151:144], 8'd0);

    // Reset mid-run clears asynchronously before the next edge
    valid = 1'b1; acc_en = 1'b1;
    step();
    rst_n = 1'b1;
    #2;
    check("midrun_reset_async", out_flat, '0);
    @(posedge clk);
    #1;
    check("midrun_reset_held", out_flat, '0);
    rst_n = 1'b0;
    exp_cnt = '0;
    step();
    check("cnt_after_midrun", out_flat[151:144], 8'd1);
    check("acc_after_midrun", out_flat[127:64], 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
